// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic B-operand path.
// Pure declarations: no latency and no flow control of its own.
package systolic_pkg;

  localparam int DEF_BITS_AB = 8;
  localparam int DEF_DIM     = 8;

  typedef logic signed [DEF_BITS_AB-1:0] b_row_t [DEF_DIM];

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } loader_state_e;

  // Zero rows needed to push the last tile row through a DIM+1 deep FIFO.
  function automatic int flush_cycles(input int dim);
    return dim + 1;
  endfunction

endpackage

// File: rtl/tile_buffer.sv
// DIM-row register file holding one B tile; one write port, one combinational read port.
// Write lands on the next clock edge; read has zero latency; no backpressure.
module tile_buffer
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM     = DEF_DIM,
  parameter int AW      = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic signed [BITS_AB-1:0] wdata [DIM],
  input  logic [AW-1:0]             raddr,
  output logic signed [BITS_AB-1:0] rdata [DIM]
);

  logic signed [BITS_AB-1:0] mem [DIM][DIM];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/b_tile_loader.sv
// Buffers one DIM x DIM B tile via valid/ready, then streams it (en_b, b_out) plus DIM+1 zero rows.
// Outputs registered one cycle after start; wr_ready is low from tile complete until flush done.
module b_tile_loader
  import systolic_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM     = DEF_DIM
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic signed [BITS_AB-1:0] wr_row [DIM],
  input  logic                      start,
  output logic                      en_b,
  output logic signed [BITS_AB-1:0] b_out [DIM],
  output logic                      tile_full,
  output logic                      busy,
  output logic                      done
);

  // Counter must reach flush_cycles(DIM) to mark the done cycle.
  localparam int CW = $clog2(DIM + 2);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  loader_state_e             state, state_d;
  logic [CW-1:0]             row_cnt, cnt_d;
  logic                      en_b_d, done_d, we;
  logic signed [BITS_AB-1:0] b_out_d [DIM];
  logic signed [BITS_AB-1:0] rdata   [DIM];

  assign wr_ready  = (state == LOAD);
  assign tile_full = (state == FULL);
  assign busy      = (state == STREAM) || (state == FLUSH);

  tile_buffer #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM),
    .AW      (AW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (row_cnt[AW-1:0]),
    .wdata (wr_row),
    .raddr (row_cnt[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      row_cnt <= '0;
      en_b    <= 1'b0;
      b_out   <= '{default: '0};
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      row_cnt <= cnt_d;
      en_b    <= en_b_d;
      b_out   <= b_out_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = row_cnt;
    en_b_d  = 1'b0;
    b_out_d = '{default: '0};
    done_d  = 1'b0;
    we      = 1'b0;
    case (state)
      LOAD: begin
        if (wr_valid) begin
          we = 1'b1;
          if (row_cnt == CW'(DIM - 1)) begin
            state_d = FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = row_cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (start) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        en_b_d  = 1'b1;
        b_out_d = rdata;
        if (row_cnt == CW'(DIM - 1)) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = row_cnt + CW'(1);
        end
      end
      FLUSH: begin
        // Extra cycle after the zero rows drops en_b and raises done.
        if (row_cnt == CW'(flush_cycles(DIM))) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          en_b_d = 1'b1;
          cnt_d  = row_cnt + CW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_b_tile_loader.sv
// Directed bench for b_tile_loader: load, stream/flush timing, ignored starts, reset, back-to-back.
module tb_b_tile_loader;

  localparam int DIM = 8;
  localparam int NK  = 20;

  logic clk = 1'b0;
  logic rst, wr_valid, wr_ready, start, en_b, tile_full, busy, done;
  logic signed [7:0] wr_row [DIM];
  logic signed [7:0] b_out  [DIM];

  logic signed [7:0] tile    [DIM][DIM];
  logic signed [7:0] cap_row [NK][DIM];
  logic              cap_en   [NK];
  logic              cap_done [NK];
  logic              cap_rdy  [NK];
  logic              cap_busy [NK];

  int n_cmp = 0;
  int n_err = 0;

  b_tile_loader #(.BITS_AB(8), .DIM(DIM)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .start     (start),
    .en_b      (en_b),
    .b_out     (b_out),
    .tile_full (tile_full),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drives tile[] row by row from a negedge; returns at the negedge after row DIM-1 is accepted.
  task automatic load_tile(input bit rand_valid, input bit start_last, output int cycles);
    int  r = 0;
    bit  acc;
    cycles = 0;
    while (r < DIM && cycles < 400) begin
      wr_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_valid) wr_row = tile[r];
      else for (int i = 0; i < DIM; i++) wr_row[i] = 8'($urandom);
      acc   = wr_valid && wr_ready;
      start = start_last && (r == DIM - 1) && acc;
      @(negedge clk);
      cycles++;
      if (acc) r++;
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    n_cmp++;
    if (r != DIM) begin
      n_err++;
      $display("FAIL load_timeout: rows accepted %0d, required %0d", r, DIM);
    end
  endtask

  // Pulses start now (caller is at a negedge) and records outputs after edges t+0..t+19.
  task automatic capture(input int restart_k);
    start = 1'b1;
    for (int k = 0; k < NK; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      cap_en[k]   = en_b;
      cap_done[k] = done;
      cap_rdy[k]  = wr_ready;
      cap_busy[k] = busy;
      for (int i = 0; i < DIM; i++) cap_row[k][i] = b_out[i];
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    bit zero;
    rst = 1'b1; wr_valid = 1'b0; start = 1'b0;
    for (int i = 0; i < DIM; i++) wr_row[i] = '0;
    @(negedge clk);
    @(negedge clk);
    zero = 1'b1;
    for (int i = 0; i < DIM; i++) if (b_out[i] !== 8'sd0) zero = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (en_b !== 1'b0) begin n_err++; $display("FAIL reset_en_b got %b want 0", en_b); end
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_b_out got nonzero want all 0"); end
    n_cmp++; if (tile_full !== 1'b0) begin n_err++; $display("FAIL reset_tile_full got %b want 0", tile_full); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load;
    int cyc;
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++) tile[r][i] = 8'(8 * r + i);
    load_tile(1'b0, 1'b0, cyc);
    n_cmp++; if (cyc != DIM) begin n_err++; $display("FAIL load_cycles got %0d want %0d", cyc, DIM); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL load_ready_drop got %b want 0", wr_ready); end
    n_cmp++; if (tile_full !== 1'b1) begin n_err++; $display("FAIL load_tile_full got %b want 1", tile_full); end
    // Writes offered while full must not disturb the buffered tile.
    wr_valid = 1'b1;
    for (int i = 0; i < DIM; i++) wr_row[i] = 8'sh55;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++;
      if (en_b !== 1'b0 || tile_full !== 1'b1 || wr_ready !== 1'b0) begin
        n_err++;
        $display("FAIL idle_full c=%0d en_b=%b tile_full=%b wr_ready=%b want 0/1/0", c, en_b, tile_full, wr_ready);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_stream;
    logic signed [7:0] exp_v;
    capture(-1);
    for (int k = 0; k < NK; k++) begin
      n_cmp++;
      if (cap_en[k] !== ((k >= 1 && k <= 17) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL stream_en_b k=%0d got %b", k, cap_en[k]);
      end
      n_cmp++;
      if (cap_done[k] !== ((k == 18) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL stream_done k=%0d got %b", k, cap_done[k]);
      end
      n_cmp++;
      if (cap_rdy[k] !== ((k >= 18) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL stream_wr_ready k=%0d got %b", k, cap_rdy[k]);
      end
      n_cmp++;
      if (cap_busy[k] !== ((k <= 17) ? 1'b1 : 1'b0)) begin
        n_err++; $display("FAIL stream_busy k=%0d got %b", k, cap_busy[k]);
      end
      for (int i = 0; i < DIM; i++) begin
        exp_v = (k >= 1 && k <= 8) ? 8'(8 * (k - 1) + i) : 8'sd0;
        n_cmp++;
        if (cap_row[k][i] !== exp_v) begin
          n_err++; $display("FAIL stream_b_out k=%0d i=%0d got %0d want %0d", k, i, cap_row[k][i], exp_v);
        end
      end
    end
  endtask

  task automatic test_ignored_start;
    int cyc, n_en;
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++) tile[r][i] = 8'(100 - 13 * r - 3 * i);
    load_tile(1'b0, 1'b1, cyc);
    @(negedge clk);
    n_cmp++;
    if (tile_full !== 1'b1 || busy !== 1'b0 || en_b !== 1'b0) begin
      n_err++; $display("FAIL start_on_last_row tile_full=%b busy=%b en_b=%b want 1/0/0", tile_full, busy, en_b);
    end
    capture(3);
    n_en = 0;
    for (int k = 0; k < NK; k++) n_en += int'(cap_en[k]);
    n_cmp++; if (n_en != 17) begin n_err++; $display("FAIL restart_en_count got %0d want 17", n_en); end
    n_cmp++; if (cap_done[18] !== 1'b1 || cap_done[17] !== 1'b0) begin
      n_err++; $display("FAIL restart_done d17=%b d18=%b want 0/1", cap_done[17], cap_done[18]);
    end
    for (int k = 1; k <= 8; k++)
      for (int i = 0; i < DIM; i++) begin
        n_cmp++;
        if (cap_row[k][i] !== 8'(100 - 13 * (k - 1) - 3 * i)) begin
          n_err++; $display("FAIL restart_b_out k=%0d i=%0d got %0d want %0d", k, i, cap_row[k][i], 100 - 13 * (k - 1) - 3 * i);
        end
      end
  endtask

  task automatic test_random_valid;
    int cyc;
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++) tile[r][i] = 8'($urandom_range(0, 255));
    tile[0][0] = 8'sh80;
    tile[0][1] = 8'sh7f;
    tile[7][7] = 8'shff;
    load_tile(1'b1, 1'b0, cyc);
    capture(-1);
    n_cmp++; if (cap_row[1][0] !== 8'sh80) begin n_err++; $display("FAIL rand_min got %0d want -128", cap_row[1][0]); end
    n_cmp++; if (cap_row[8][7] !== -8'sd1) begin n_err++; $display("FAIL rand_neg1 got %0d want -1", cap_row[8][7]); end
    for (int k = 1; k <= 8; k++)
      for (int i = 0; i < DIM; i++) begin
        n_cmp++;
        if (cap_row[k][i] !== tile[k-1][i]) begin
          n_err++; $display("FAIL rand_b_out k=%0d i=%0d got %0d want %0d", k, i, cap_row[k][i], tile[k-1][i]);
        end
      end
  endtask

  task automatic test_reset_mid;
    int  cyc;
    bit  zero;
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++) tile[r][i] = 8'(-5 * r + i);
    load_tile(1'b0, 1'b0, cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (b_out[2] !== 8'(-15 + 2)) begin n_err++; $display("FAIL mid_row3 got %0d want -13", b_out[2]); end
    rst = 1'b1;
    @(negedge clk);
    zero = 1'b1;
    for (int i = 0; i < DIM; i++) if (b_out[i] !== 8'sd0) zero = 1'b0;
    n_cmp++;
    if (en_b !== 1'b0 || zero !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 || tile_full !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_reset en_b=%b zero=%b busy=%b wr_ready=%b tile_full=%b done=%b want 0/1/0/1/0/0",
                        en_b, zero, busy, wr_ready, tile_full, done);
    end
    rst = 1'b0;
    // Partial load of junk rows, then reset: the next load must restart at row 0.
    wr_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < DIM; i++) wr_row[i] = 8'sh33;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++) tile[r][i] = 8'(20 * r - 7 * i);
    load_tile(1'b0, 1'b0, cyc);
    n_cmp++; if (cyc != DIM) begin n_err++; $display("FAIL reload_cycles got %0d want %0d", cyc, DIM); end
    capture(-1);
    for (int k = 1; k <= 8; k++)
      for (int i = 0; i < DIM; i++) begin
        n_cmp++;
        if (cap_row[k][i] !== 8'(20 * (k - 1) - 7 * i)) begin
          n_err++; $display("FAIL reload_b_out k=%0d i=%0d got %0d want %0d", k, i, cap_row[k][i], 20 * (k - 1) - 7 * i);
        end
      end
  endtask

  task automatic test_back_to_back;
    int cyc, n_en;
    logic signed [7:0] exp_v;
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < DIM; r++)
        for (int i = 0; i < DIM; i++) tile[r][i] = 8'((t == 0) ? (r + 1) : -(i + 2));
      load_tile(1'b0, 1'b0, cyc);
      n_cmp++; if (tile_full !== 1'b1) begin n_err++; $display("FAIL b2b_full tile=%0d got %b want 1", t, tile_full); end
      capture(-1);
      n_en = 0;
      for (int k = 0; k < NK; k++) n_en += int'(cap_en[k]);
      n_cmp++; if (n_en != 17 || cap_en[1] !== 1'b1 || cap_en[17] !== 1'b1) begin
        n_err++; $display("FAIL b2b_burst tile=%0d count=%0d want 17", t, n_en);
      end
      for (int k = 1; k <= 17; k++)
        for (int i = 0; i < DIM; i++) begin
          exp_v = (k > 8) ? 8'sd0 : ((t == 0) ? 8'(k) : 8'(-(i + 2)));
          n_cmp++;
          if (cap_row[k][i] !== exp_v) begin
            n_err++; $display("FAIL b2b_b_out tile=%0d k=%0d i=%0d got %0d want %0d", t, k, i, cap_row[k][i], exp_v);
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream();
    test_ignored_start();
    test_random_valid();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
